secded_stream_decoder: RTL and testbench

SECDED_STREAM_DECODER -- requirements
Module: secded_stream_decoder

---
 rtl/secded_pkg.sv | 41 ++++
 rtl/secded_syndrome.sv | 24 ++
 rtl/secded_stream_decoder.sv | 122 ++++++++++++
 tb/tb_secded_stream_decoder.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/secded_pkg.sv
// Shared definitions for the SECDED stream decoder.
//   parity_width : number of Hamming check bits needed for a given data width
//   err_class_e  : per-word error classification
//   data_pos     : code-word position that carries data bit idx
package secded_pkg;

  localparam int MAX_CODE_W = 64;

  typedef enum logic [1:0] {
    NONE   = 2'd0,
    SINGLE = 2'd1,
    DOUBLE = 2'd2
  } err_class_e;

  // Smallest r with 2^r >= data_w + r + 1. Scanning downwards leaves the
  // smallest satisfying r in place.
  function automatic int parity_width(input int data_w);
    int r;
    r = 0;
    for (int i = 7; i >= 1; i--) begin
      if ((1 << i) >= data_w + i + 1) r = i;
    end
    return r;
  endfunction

  // Data bits fill every non-power-of-two position from 3 upwards, in order.
  function automatic int data_pos(input int idx);
    int p;
    int n;
    p = 0;
    n = -1;
    for (int q = 1; q < MAX_CODE_W; q++) begin
      if ((q & (q - 1)) != 0) begin
        n = n + 1;
        if (n == idx) p = q;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/secded_syndrome.sv
// Combinational Hamming syndrome and overall parity of one code word.
//   code     : received code word (bit 0 = overall parity)
//   syndrome : bit k = XOR of positions 1..CODE_W-1 whose index has bit k set
//   parity   : XOR of all CODE_W bits
module secded_syndrome #(
  parameter int CODE_W   = 13,
  parameter int PARITY_W = $clog2(CODE_W)
) (
  input  logic [CODE_W-1:0]   code,
  output logic [PARITY_W-1:0] syndrome,
  output logic                parity
);

  always_comb begin
    syndrome = '0;
    for (int p = 1; p < CODE_W; p++) begin
      for (int k = 0; k < PARITY_W; k++) begin
        if (((p >> k) & 1) == 1) syndrome[k] = syndrome[k] ^ code[p];
      end
    end
    parity = ^code;
  end

endmodule

// File: rtl/secded_stream_decoder.sv
// Two-stage SECDED decoder on a valid/ready stream with saturating error counters.
//   clock, reset          : rising-edge clock, synchronous active-high reset
//   in_valid/in_ready     : input handshake; in_code + correct_en sampled together
//   out_valid/out_ready   : output handshake
//   out_code, out_data    : corrected (or passed-through) word and its data bits
//   syndrome              : Hamming syndrome of the received word
//   is1BitErr, is2BitErr  : single (correctable) / uncorrectable error flags
//   clr_counts            : clears both counters, wins over an increment
//   cnt_1bit, cnt_2bit    : saturating counts of delivered flagged results
module secded_stream_decoder
  import secded_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16,
  localparam int PARITY_W = parity_width(DATA_W),
  localparam int CODE_W   = DATA_W + PARITY_W + 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [CODE_W-1:0]   in_code,
  input  logic                correct_en,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CODE_W-1:0]   out_code,
  output logic [DATA_W-1:0]   out_data,
  output logic [PARITY_W-1:0] syndrome,
  output logic                is1BitErr,
  output logic                is2BitErr,
  input  logic                clr_counts,
  output logic [CNT_W-1:0]    cnt_1bit,
  output logic [CNT_W-1:0]    cnt_2bit
);

  localparam logic [PARITY_W:0] CODE_W_V = (PARITY_W + 1)'(CODE_W);

  logic                en;
  logic [PARITY_W-1:0] syn_c;
  logic                par_c;

  logic                s1_valid;
  logic [CODE_W-1:0]   s1_code;
  logic [PARITY_W-1:0] s1_syn;
  logic                s1_par;
  logic                s1_cen;

  err_class_e          cls;
  logic [CODE_W-1:0]   flip;
  logic [CODE_W-1:0]   corr;
  logic [DATA_W-1:0]   corr_data;

  // Whole pipeline stalls only when a result is waiting and not taken.
  assign en       = ~out_valid | out_ready;
  assign in_ready = en;

  secded_syndrome #(
    .CODE_W   (CODE_W),
    .PARITY_W (PARITY_W)
  ) u_syn (
    .code     (in_code),
    .syndrome (syn_c),
    .parity   (par_c)
  );

  // A syndrome pointing past the last code bit can only come from a multi-bit
  // error, so odd parity with such a syndrome is classed as uncorrectable.
  always_comb begin
    cls = NONE;
    if (s1_par) cls = ({1'b0, s1_syn} < CODE_W_V) ? SINGLE : DOUBLE;
    else if (s1_syn != '0) cls = DOUBLE;

    flip = '0;
    if (cls == SINGLE && s1_cen) flip = CODE_W'(1) << s1_syn;
    corr = s1_code ^ flip;

    corr_data = '0;
    for (int i = 0; i < DATA_W; i++) corr_data[i] = corr[data_pos(i)];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s1_code   <= '0;
      s1_syn    <= '0;
      s1_par    <= 1'b0;
      s1_cen    <= 1'b0;
      out_valid <= 1'b0;
      out_code  <= '0;
      out_data  <= '0;
      syndrome  <= '0;
      is1BitErr <= 1'b0;
      is2BitErr <= 1'b0;
      cnt_1bit  <= '0;
      cnt_2bit  <= '0;
    end else begin
      if (en) begin
        s1_valid  <= in_valid;
        s1_code   <= in_code;
        s1_syn    <= syn_c;
        s1_par    <= par_c;
        s1_cen    <= correct_en;
        out_valid <= s1_valid;
        out_code  <= corr;
        out_data  <= corr_data;
        syndrome  <= s1_syn;
        // Flags stay low for bubbles so an idle output never looks like an error.
        is1BitErr <= s1_valid && (cls == SINGLE);
        is2BitErr <= s1_valid && (cls == DOUBLE);
      end

      if (clr_counts) begin
        cnt_1bit <= '0;
        cnt_2bit <= '0;
      end else if (out_valid && out_ready) begin
        if (is1BitErr && cnt_1bit != '1) cnt_1bit <= cnt_1bit + CNT_W'(1);
        if (is2BitErr && cnt_2bit != '1) cnt_2bit <= cnt_2bit + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_secded_stream_decoder.sv
module tb_secded_stream_decoder;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [12:0] in_code;
  logic        correct_en;
  logic        out_valid;
  logic        out_ready;
  logic [12:0] out_code;
  logic [7:0]  out_data;
  logic [3:0]  syndrome;
  logic        is1BitErr;
  logic        is2BitErr;
  logic        clr_counts;
  logic [3:0]  cnt_1bit;
  logic [3:0]  cnt_2bit;

  int n_checks = 0;
  int n_fail   = 0;

  // Narrow counters so saturation is reachable in a few cycles.
  secded_stream_decoder #(
    .DATA_W (8),
    .CNT_W  (4)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_code    (in_code),
    .correct_en (correct_en),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_code   (out_code),
    .out_data   (out_data),
    .syndrome   (syndrome),
    .is1BitErr  (is1BitErr),
    .is2BitErr  (is2BitErr),
    .clr_counts (clr_counts),
    .cnt_1bit   (cnt_1bit),
    .cnt_2bit   (cnt_2bit)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [12:0] code, input logic cen);
    in_valid   = 1'b1;
    in_code    = code;
    correct_en = cen;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_code = '0; correct_en = 1'b1;
    out_ready = 1'b1; clr_counts = 1'b0;
    tick(); tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (out_code !== 13'h0000) begin n_fail++; $display("FAIL reset_out_code: got %h expected 0000", out_code); end
    n_checks++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out_data: got %h expected 00", out_data); end
    n_checks++; if (syndrome !== 4'd0) begin n_fail++; $display("FAIL reset_syndrome: got %0d expected 0", syndrome); end
    n_checks++; if ({is1BitErr, is2BitErr} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %b expected 00", {is1BitErr, is2BitErr}); end
    n_checks++; if ({cnt_1bit, cnt_2bit} !== 8'h00) begin n_fail++; $display("FAIL reset_counts: got %h expected 00", {cnt_1bit, cnt_2bit}); end
    reset = 1'b0;
    tick();
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_clean();
    drive(13'h144E, 1'b1);
    tick(); in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL clean_latency: got out_valid %b expected 0 one cycle after accept", out_valid); end
    tick();
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL clean_valid: got %b expected 1", out_valid); end
    n_checks++; if (out_code !== 13'h144E) begin n_fail++; $display("FAIL clean_code: got %h expected 144e", out_code); end
    n_checks++; if (out_data !== 8'hA5) begin n_fail++; $display("FAIL clean_data: got %h expected a5", out_data); end
    n_checks++; if (syndrome !== 4'd0) begin n_fail++; $display("FAIL clean_syndrome: got %0d expected 0", syndrome); end
    n_checks++; if ({is1BitErr, is2BitErr} !== 2'b00) begin n_fail++; $display("FAIL clean_flags: got %b expected 00", {is1BitErr, is2BitErr}); end
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL clean_drain: got out_valid %b expected 0", out_valid); end
    n_checks++; if ({cnt_1bit, cnt_2bit} !== 8'h00) begin n_fail++; $display("FAIL clean_counts: got %h expected 00", {cnt_1bit, cnt_2bit}); end
  endtask

  task automatic test_single();
    drive(13'h140E, 1'b1);
    tick(); in_valid = 1'b0;
    tick();
    n_checks++; if (syndrome !== 4'd6) begin n_fail++; $display("FAIL single_syndrome: got %0d expected 6", syndrome); end
    n_checks++; if ({is1BitErr, is2BitErr} !== 2'b10) begin n_fail++; $display("FAIL single_flags: got %b expected 10", {is1BitErr, is2BitErr}); end
    n_checks++; if (out_code !== 13'h144E) begin n_fail++; $display("FAIL single_code: got %h expected 144e", out_code); end
    n_checks++; if (out_data !== 8'hA5) begin n_fail++; $display("FAIL single_data: got %h expected a5", out_data); end
    tick();
    n_checks++; if (cnt_1bit !== 4'd1) begin n_fail++; $display("FAIL single_cnt1: got %0d expected 1", cnt_1bit); end
  endtask

  task automatic test_detect_only();
    drive(13'h140E, 1'b0);
    tick(); in_valid = 1'b0;
    tick();
    n_checks++; if (out_code !== 13'h140E) begin n_fail++; $display("FAIL detect_code: got %h expected 140e", out_code); end
    n_checks++; if (out_data !== 8'hA1) begin n_fail++; $display("FAIL detect_data: got %h expected a1", out_data); end
    n_checks++; if (syndrome !== 4'd6) begin n_fail++; $display("FAIL detect_syndrome: got %0d expected 6", syndrome); end
    n_checks++; if ({is1BitErr, is2BitErr} !== 2'b10) begin n_fail++; $display("FAIL detect_flags: got %b expected 10", {is1BitErr, is2BitErr}); end
    tick();
    n_checks++; if (cnt_1bit !== 4'd2) begin n_fail++; $display("FAIL detect_cnt1: got %0d expected 2", cnt_1bit); end
  endtask

  task automatic test_parity_bit();
    drive(13'h144F, 1'b1);
    tick(); in_valid = 1'b0;
    tick();
    n_checks++; if (syndrome !== 4'd0) begin n_fail++; $display("FAIL pbit_syndrome: got %0d expected 0", syndrome); end
    n_checks++; if ({is1BitErr, is2BitErr} !== 2'b10) begin n_fail++; $display("FAIL pbit_flags: got %b expected 10", {is1BitErr, is2BitErr}); end
    n_checks++; if (out_code !== 13'h144E) begin n_fail++; $display("FAIL pbit_code: got %h expected 144e", out_code); end
    n_checks++; if (out_data !== 8'hA5) begin n_fail++; $display("FAIL pbit_data: got %h expected a5", out_data); end
    tick();
    n_checks++; if (cnt_1bit !== 4'd3) begin n_fail++; $display("FAIL pbit_cnt1: got %0d expected 3", cnt_1bit); end
  endtask

  task automatic test_double();
    drive(13'h1466, 1'b1);
    tick(); in_valid = 1'b0;
    tick();
    n_checks++; if (syndrome !== 4'd6) begin n_fail++; $display("FAIL double_syndrome: got %0d expected 6", syndrome); end
    n_checks++; if ({is1BitErr, is2BitErr} !== 2'b01) begin n_fail++; $display("FAIL double_flags: got %b expected 01", {is1BitErr, is2BitErr}); end
    n_checks++; if (out_code !== 13'h1466) begin n_fail++; $display("FAIL double_code: got %h expected 1466", out_code); end
    n_checks++; if (out_data !== 8'hA6) begin n_fail++; $display("FAIL double_data: got %h expected a6", out_data); end
    tick();
    n_checks++; if ({cnt_1bit, cnt_2bit} !== {4'd3, 4'd1}) begin n_fail++; $display("FAIL double_counts: got %h expected 31", {cnt_1bit, cnt_2bit}); end
  endtask

  task automatic test_invalid_syndrome();
    drive(13'h044D, 1'b1);
    tick(); in_valid = 1'b0;
    tick();
    n_checks++; if (syndrome !== 4'd13) begin n_fail++; $display("FAIL invsyn_syndrome: got %0d expected 13", syndrome); end
    n_checks++; if ({is1BitErr, is2BitErr} !== 2'b01) begin n_fail++; $display("FAIL invsyn_flags: got %b expected 01", {is1BitErr, is2BitErr}); end
    n_checks++; if (out_code !== 13'h044D) begin n_fail++; $display("FAIL invsyn_code: got %h expected 044d", out_code); end
    tick();
    n_checks++; if (cnt_2bit !== 4'd2) begin n_fail++; $display("FAIL invsyn_cnt2: got %0d expected 2", cnt_2bit); end
  endtask

  task automatic test_back_to_back();
    drive(13'h144F, 1'b1);
    tick();
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready0: got %b expected 1", in_ready); end
    drive(13'h1466, 1'b1);
    tick();
    n_checks++; if ({out_valid, out_code, is1BitErr} !== {1'b1, 13'h144E, 1'b1}) begin n_fail++; $display("FAIL b2b_word0: got v%b %h e1=%b expected v1 144e e1=1", out_valid, out_code, is1BitErr); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready1: got %b expected 1", in_ready); end
    drive(13'h144E, 1'b1);
    tick(); in_valid = 1'b0;
    n_checks++; if ({out_valid, out_code, is2BitErr} !== {1'b1, 13'h1466, 1'b1}) begin n_fail++; $display("FAIL b2b_word1: got v%b %h e2=%b expected v1 1466 e2=1", out_valid, out_code, is2BitErr); end
    tick();
    n_checks++; if ({out_valid, out_code, is1BitErr, is2BitErr} !== {1'b1, 13'h144E, 2'b00}) begin n_fail++; $display("FAIL b2b_word2: got v%b %h flags %b%b expected v1 144e flags 00", out_valid, out_code, is1BitErr, is2BitErr); end
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: got %b expected 0", out_valid); end
    n_checks++; if ({cnt_1bit, cnt_2bit} !== {4'd4, 4'd3}) begin n_fail++; $display("FAIL b2b_counts: got %h expected 43", {cnt_1bit, cnt_2bit}); end
  endtask

  task automatic test_backpressure();
    drive(13'h144E, 1'b1);
    tick();
    drive(13'h140E, 1'b0);
    tick();
    n_checks++; if ({out_valid, out_code} !== {1'b1, 13'h144E}) begin n_fail++; $display("FAIL bp_word0: got v%b %h expected v1 144e", out_valid, out_code); end
    drive(13'h044D, 1'b1);
    tick(); in_valid = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_stall_ready[%0d]: got %b expected 0", i, in_ready); end
      n_checks++; if ({out_valid, out_code, out_data, syndrome, is1BitErr, is2BitErr} !== {1'b1, 13'h140E, 8'hA1, 4'd6, 2'b10})
        begin n_fail++; $display("FAIL bp_stall_hold[%0d]: got v%b %h %h s%0d %b%b expected v1 140e a1 s6 10", i, out_valid, out_code, out_data, syndrome, is1BitErr, is2BitErr); end
    end
    n_checks++; if ({cnt_1bit, cnt_2bit} !== {4'd4, 4'd3}) begin n_fail++; $display("FAIL bp_stall_counts: got %h expected 43", {cnt_1bit, cnt_2bit}); end
    out_ready = 1'b1;
    tick();
    n_checks++; if ({out_valid, out_code, is2BitErr} !== {1'b1, 13'h044D, 1'b1}) begin n_fail++; $display("FAIL bp_word2: got v%b %h e2=%b expected v1 044d e2=1", out_valid, out_code, is2BitErr); end
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain: got %b expected 0", out_valid); end
    n_checks++; if ({cnt_1bit, cnt_2bit} !== {4'd5, 4'd4}) begin n_fail++; $display("FAIL bp_counts: got %h expected 54", {cnt_1bit, cnt_2bit}); end
  endtask

  task automatic test_clr_counts();
    drive(13'h140E, 1'b1);
    tick(); in_valid = 1'b0;
    tick();
    n_checks++; if ({out_valid, is1BitErr} !== 2'b11) begin n_fail++; $display("FAIL clr_pre: got v%b e1=%b expected v1 e1=1", out_valid, is1BitErr); end
    clr_counts = 1'b1;
    tick();
    clr_counts = 1'b0;
    n_checks++; if ({cnt_1bit, cnt_2bit} !== 8'h00) begin n_fail++; $display("FAIL clr_counts: got %h expected 00", {cnt_1bit, cnt_2bit}); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 17; i++) begin
      drive(13'h140E, 1'b1);
      tick();
    end
    in_valid = 1'b0;
    tick(); tick(); tick();
    n_checks++; if (cnt_1bit !== 4'd15) begin n_fail++; $display("FAIL sat_cnt1: got %0d expected 15", cnt_1bit); end
    n_checks++; if (cnt_2bit !== 4'd0) begin n_fail++; $display("FAIL sat_cnt2: got %0d expected 0", cnt_2bit); end
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0;
    drive(13'h1466, 1'b1);
    tick();
    drive(13'h140E, 1'b1);
    tick();
    n_checks++; if ({out_valid, is2BitErr} !== 2'b11) begin n_fail++; $display("FAIL mid_pre: got v%b e2=%b expected v1 e2=1", out_valid, is2BitErr); end
    reset = 1'b1;
    tick();
    reset = 1'b0; in_valid = 1'b0;
    n_checks++; if ({out_valid, is1BitErr, is2BitErr, syndrome} !== 7'd0) begin n_fail++; $display("FAIL mid_state: got v%b %b%b s%0d expected all 0", out_valid, is1BitErr, is2BitErr, syndrome); end
    n_checks++; if ({out_code, out_data} !== 21'd0) begin n_fail++; $display("FAIL mid_data: got %h %h expected 0 0", out_code, out_data); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_in_ready: got %b expected 1", in_ready); end
    n_checks++; if ({cnt_1bit, cnt_2bit} !== 8'h00) begin n_fail++; $display("FAIL mid_counts: got %h expected 00", {cnt_1bit, cnt_2bit}); end
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_flush1: got %b expected 0", out_valid); end
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_flush2: got %b expected 0", out_valid); end
    out_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_clean();
    test_single();
    test_detect_only();
    test_parity_bit();
    test_double();
    test_invalid_syndrome();
    test_back_to_back();
    test_backpressure();
    test_clr_counts();
    test_saturation();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
